// File: rtl/quiz_setup_ctrl.sv
// Four-field game setup controller: range-checked entry into shadow registers, atomic commit on the last field.
// Optional build macro QUIZ_SETUP_BACK_EN enables stepping back one field with back_btn.
module quiz_setup_ctrl #(
    parameter int               VAL_W       = 6,
    parameter logic [VAL_W-1:0] MIN_PEOPLE  = VAL_W'(2),
    parameter logic [VAL_W-1:0] MAX_PEOPLE  = VAL_W'(4),
    parameter logic [VAL_W-1:0] MIN_SECONDS = VAL_W'(1),
    parameter logic [VAL_W-1:0] MAX_SECONDS = {VAL_W{1'b1}},
    parameter logic [VAL_W-1:0] MIN_POINT   = VAL_W'(1),
    parameter logic [VAL_W-1:0] MAX_POINT   = {VAL_W{1'b1}},
    parameter logic [VAL_W-1:0] DEF_PEOPLE  = VAL_W'(4),
    parameter logic [VAL_W-1:0] DEF_SECONDS = VAL_W'(10),
    parameter logic [VAL_W-1:0] DEF_CORRECT = VAL_W'(1),
    parameter logic [VAL_W-1:0] DEF_MISTAKE = VAL_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             setting_en,
    input  logic             enter_btn,
    input  logic             back_btn,
    input  logic [VAL_W-1:0] input_val,
    output logic [VAL_W-1:0] num_people,
    output logic [VAL_W-1:0] count_seconds,
    output logic [VAL_W-1:0] correct_point,
    output logic [VAL_W-1:0] mistake_point,
    output logic [2:0]       cur_field,
    output logic             is_set_over,
    output logic             reject,
    output logic             disp_en,
    output logic [VAL_W-1:0] disp_val
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PEOPLE  = 3'd1,
        SECONDS = 3'd2,
        CORRECT = 3'd3,
        MISTAKE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [VAL_W-1:0] set_people_q, set_seconds_q, set_correct_q, set_mistake_q;
    logic [VAL_W-1:0] set_people_d, set_seconds_d, set_correct_d, set_mistake_d;
    logic [VAL_W-1:0] sh_people_q, sh_seconds_q, sh_correct_q, sh_mistake_q;
    logic [VAL_W-1:0] sh_people_d, sh_seconds_d, sh_correct_d, sh_mistake_d;
    logic             reject_q, reject_d;
    logic [VAL_W-1:0] disp_val_q;
    logic             enter_s1_q, enter_s2_q, enter_dly_q;
    logic             enter_evt, back_evt;
    logic [VAL_W-1:0] lim_lo, lim_hi;
    logic             in_range;

    // Two synchroniser stages plus an edge-detect stage: a held button yields one event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_s1_q  <= 1'b0;
            enter_s2_q  <= 1'b0;
            enter_dly_q <= 1'b0;
        end else begin
            enter_s1_q  <= enter_btn;
            enter_s2_q  <= enter_s1_q;
            enter_dly_q <= enter_s2_q;
        end
    end
    assign enter_evt = enter_s2_q & ~enter_dly_q;

`ifdef QUIZ_SETUP_BACK_EN
    logic back_s1_q, back_s2_q, back_dly_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            back_s1_q  <= 1'b0;
            back_s2_q  <= 1'b0;
            back_dly_q <= 1'b0;
        end else begin
            back_s1_q  <= back_btn;
            back_s2_q  <= back_s1_q;
            back_dly_q <= back_s2_q;
        end
    end
    assign back_evt = back_s2_q & ~back_dly_q;
`else
    logic back_unused;
    assign back_unused = back_btn;
    assign back_evt    = 1'b0;
`endif

    always_comb begin
        lim_lo = MIN_PEOPLE;
        lim_hi = MAX_PEOPLE;
        case (state_q)
            SECONDS:          begin lim_lo = MIN_SECONDS; lim_hi = MAX_SECONDS; end
            CORRECT, MISTAKE: begin lim_lo = MIN_POINT;   lim_hi = MAX_POINT;   end
            default: ;
        endcase
    end
    assign in_range = (input_val >= lim_lo) && (input_val <= lim_hi);

    always_comb begin
        state_d       = state_q;
        set_people_d  = set_people_q;
        set_seconds_d = set_seconds_q;
        set_correct_d = set_correct_q;
        set_mistake_d = set_mistake_q;
        sh_people_d   = sh_people_q;
        sh_seconds_d  = sh_seconds_q;
        sh_correct_d  = sh_correct_q;
        sh_mistake_d  = sh_mistake_q;
        reject_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (setting_en) begin
                    state_d      = PEOPLE;
                    sh_people_d  = set_people_q;
                    sh_seconds_d = set_seconds_q;
                    sh_correct_d = set_correct_q;
                    sh_mistake_d = set_mistake_q;
                end
            end
            PEOPLE, SECONDS, CORRECT, MISTAKE: begin
                if (!setting_en) begin
                    state_d = IDLE;
                end else if (enter_evt) begin
                    if (!in_range) begin
                        reject_d = 1'b1;
                    end else begin
                        case (state_q)
                            PEOPLE:  begin sh_people_d  = input_val; state_d = SECONDS; end
                            SECONDS: begin sh_seconds_d = input_val; state_d = CORRECT; end
                            CORRECT: begin sh_correct_d = input_val; state_d = MISTAKE; end
                            default: begin
                                // Last field: commit all four settings on this same edge.
                                sh_mistake_d  = input_val;
                                set_people_d  = sh_people_q;
                                set_seconds_d = sh_seconds_q;
                                set_correct_d = sh_correct_q;
                                set_mistake_d = input_val;
                                state_d       = DONE;
                            end
                        endcase
                    end
                end else if (back_evt && state_q != PEOPLE) begin
                    state_d = state_t'(state_q - 3'd1);
                end
            end
            DONE: begin
                if (!setting_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            set_people_q  <= DEF_PEOPLE;
            set_seconds_q <= DEF_SECONDS;
            set_correct_q <= DEF_CORRECT;
            set_mistake_q <= DEF_MISTAKE;
            sh_people_q   <= DEF_PEOPLE;
            sh_seconds_q  <= DEF_SECONDS;
            sh_correct_q  <= DEF_CORRECT;
            sh_mistake_q  <= DEF_MISTAKE;
            reject_q      <= 1'b0;
            disp_val_q    <= '0;
        end else begin
            state_q       <= state_d;
            set_people_q  <= set_people_d;
            set_seconds_q <= set_seconds_d;
            set_correct_q <= set_correct_d;
            set_mistake_q <= set_mistake_d;
            sh_people_q   <= sh_people_d;
            sh_seconds_q  <= sh_seconds_d;
            sh_correct_q  <= sh_correct_d;
            sh_mistake_q  <= sh_mistake_d;
            reject_q      <= reject_d;
            disp_val_q    <= input_val;
        end
    end

    assign num_people    = set_people_q;
    assign count_seconds = set_seconds_q;
    assign correct_point = set_correct_q;
    assign mistake_point = set_mistake_q;
    assign cur_field     = state_q;
    assign disp_en       = state_q inside {PEOPLE, SECONDS, CORRECT, MISTAKE};
    assign is_set_over   = ~disp_en;
    assign reject        = reject_q;
    assign disp_val      = disp_en ? disp_val_q : '0;

endmodule

// File: doc/quiz_setup_ctrl.md
# quiz_setup_ctrl

Parametrised setup controller for the multichannel answering machine: walks the host through four game settings (players, countdown seconds, correct-answer points, mistake points) entered on `input_val` and confirmed with `enter_btn`. Values are range-checked against per-field limits, staged in shadow registers and committed atomically when the last field is accepted. It feeds the game core, which only reads settings while `is_set_over` is high, and drives the tube display module during setup.

## Interface
- `VAL_W`, 6: width of `input_val` and all setting outputs.
- `MIN_PEOPLE`, 2 / `MAX_PEOPLE`, 4: accepted player-count range.
- `MIN_SECONDS`, 1 / `MAX_SECONDS`, 2^VAL_W-1: accepted countdown range.
- `MIN_POINT`, 1 / `MAX_POINT`, 2^VAL_W-1: accepted range for both point fields.
- `DEF_PEOPLE` 4, `DEF_SECONDS` 10, `DEF_CORRECT` 1, `DEF_MISTAKE` 1: reset values.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `setting_en` in 1: level; high requests setup mode.
- `enter_btn` in 1: async button; confirms the current field.
- `back_btn` in 1: async button; steps back one field. Present in all builds.
- `input_val` in VAL_W: value being entered.
- `num_people`, `count_seconds`, `correct_point`, `mistake_point` out VAL_W each: committed settings.
- `cur_field` out 3: 0 IDLE, 1 PEOPLE, 2 SECONDS, 3 CORRECT, 4 MISTAKE, 5 DONE.
- `is_set_over` out 1: high when no setup is in progress.
- `reject` out 1: one-cycle pulse when an enter is refused.
- `disp_en` out 1, `disp_val` out VAL_W: drive to the tube display.

## Operation
- Reset values: settings = DEF_*; `cur_field`=0; `is_set_over`=1; `reject`=0; `disp_en`=0; `disp_val`=0; shadows = DEF_*.
- Each button passes through a 2-flop synchroniser plus an edge-detect flop. A press is a synchronised 0→1 edge. A held button produces exactly one event.
- IDLE: `setting_en`=1 → PEOPLE. Shadows are loaded from the committed outputs. `is_set_over` goes 0.
- PEOPLE, SECONDS, CORRECT, MISTAKE, on an enter event:
  - If MIN ≤ `input_val` ≤ MAX (unsigned), the value goes into the field's shadow and the state advances.
  - Otherwise the shadow is unchanged, the state holds, and `reject` pulses.
- MISTAKE accepted → DONE. On the same edge all four shadows copy to the outputs and `is_set_over` goes 1.
- DONE: holds until `setting_en`=0, then → IDLE. Further enter events are ignored.
- `setting_en`=0 in any SET state aborts to IDLE:
  - Shadows are discarded and outputs are unchanged.
  - `is_set_over`=1 on the next edge.
- Enter and back events in the same cycle: enter wins.
- Events arriving while `setting_en`=0 are ignored.
- `disp_en`=1 in the SET states only. `disp_val` = registered `input_val` while `disp_en`=1, else 0.
- Asserting `rst` at any time returns everything to the reset values immediately; no partial commit.

## Timing
- Button rising edge → action on the 3rd rising `clk` edge after it, i.e. 2 sync stages plus 1 edge-detect stage. Outputs update after that edge.
- `setting_en` is synchronous with `clk` and takes effect on the next edge.
- `reject` is high for exactly one cycle, aligned with the edge that would have accepted.
- Commit, `cur_field`=5 and `is_set_over`=1 all change on the same edge.
- `disp_val` lags `input_val` by 1 cycle.

## Configuration
- `QUIZ_SETUP_BACK_EN` defined:
  - A back event in SECONDS, CORRECT or MISTAKE returns to the previous field. The shadow already held for that field is kept.
  - A back event in PEOPLE, DONE or IDLE is ignored.
- Not defined: `back_btn` is unused, its synchroniser is not built, and the field order is strictly forward.

## Test plan
- Reset → outputs 4/10/1/1, `is_set_over`=1, `cur_field`=0, `disp_en`=0.
- Enter 3, 20, 5, 2 in turn → `cur_field` 1→2→3→4→5; outputs become 3/20/5/2 together on the final accept; `is_set_over`=1 on that edge.
- PEOPLE with `input_val`=5 then 1 → two `reject` pulses, `cur_field` stays 1; then 2 → accepted.
- Abort after SECONDS accepted (=30): drop `setting_en` → IDLE; outputs still the previous committed values; `is_set_over`=1.
- Hold `enter_btn` for 50 cycles → exactly one advance. Enter and back in the same cycle → advance.
- With `QUIZ_SETUP_BACK_EN`: at CORRECT press back → `cur_field`=2; press back at PEOPLE → no change.
